drm_activator_stream_endpoint: RTL and testbench
================================================

// Module: drm_activator_stream_endpoint
// PURPOSE
// User-IP-side terminator of the DRM bus carried over AXI4-Stream. Decodes controller beats (dat/we/adr/cyc/cs),
// runs a bit-serial 4-register slave, returns dat/sta/intr/ack beats to the DRM controller.
// Exports activation state and counts metering events from user logic.
// PARAMETERS
// DATA_W       32  register width = data beats per transaction (2..32)
// METER_THRESH 1   intr asserted while meter_count >= METER_THRESH (1..2^DATA_W-1)
// PORTS
// drm_aclk           in   1      sole clock
// drm_arstn          in   1      reset, asynchronous, active-low
// drm_to_uip_tvalid  in   1      controller beat valid
// drm_to_uip_tdata   in   32     [0]dat [1]we [3:2]adr [4]cyc [5]cs; [31:6] ignored
// drm_to_uip_tready  out  1      beat accept
// uip_to_drm_tvalid  out  1      response beat valid
// uip_to_drm_tdata   out  32     [0]dat [1]sta [2]intr [3]ack; [31:4]=0
// uip_to_drm_tready  in   1      response accept
// metering_event     in   1      one-cycle pulse per metered user event
// activated          out  1      ctrl[0]
// activation_code    out  DATA_W ctrl register
// BEHAVIOUR
// Reset (async assert, sync deassert use): state IDLE, all regs 0, uip_to_drm_tvalid=0, tdata=0, activated=0,
//   activation_code=0; drm_to_uip_tready=0 while drm_arstn=0.
// Beat = drm_to_uip_tvalid & drm_to_uip_tready. drm_to_uip_tready = ~uip_to_drm_tvalid | uip_to_drm_tready.
// Every accepted beat yields exactly one response beat, registered, 1 cycle later; held stable while tready=0.
// Registers: adr0 STATUS RO {..,intr,activated}, write-1 bit1 clears meter_count; adr1 CTRL RW;
//   adr2 METER RO saturating count of metering_event, any write clears; adr3 SCRATCH RW.
// FSM (advances on beats only):
//   IDLE : cyc&cs -> capture we,adr; if read load shift reg with reg[adr]; bitcnt=0; -> DATA.
//          cyc&~cs -> SKIP. else stay. Header beat response: dat=0, ack=0.
//   DATA : cyc=0 -> IDLE (abort, no write, no ack). else write: shift in dat (MSB first);
//          read: response dat = shift reg MSB (bit DATA_W-1-bitcnt). bitcnt==DATA_W-1 -> ACK.
//   ACK  : cyc=0 -> IDLE abort. else response ack=1, write committed to reg[adr] this beat -> WAIT.
//   WAIT : response ack=0; cyc=0 -> IDLE. Extra cyc=1 beats ignored.
//   SKIP : response dat=0, ack=0; cyc=0 -> IDLE.
// Read snapshot taken at header beat; later register changes do not affect serialized bits.
// sta/intr in each response = values at response-register load time. intr = (meter_count >= METER_THRESH).
// meter_count: +1 per metering_event, saturates at 2^DATA_W-1; clear and event same cycle -> count=1.
// Writes to RO adr0 other than bit1 ignored; bits [31:4] of output always 0.
// Reset mid-transaction -> IDLE, pending response beat dropped, no register update.
// TESTING
// 1 Write 0x0000_0001 to adr1 (header+32 bits+ack beat) -> ack=1 on beat 34 response, activated=1, sta=1 after.
// 2 5 metering_event pulses, read adr2 -> 32 dat bits = 0x0000_0005 MSB first; intr=1 (THRESH=1); write adr2 -> intr=0.
// 3 Write adr3, drop cyc after 10 data beats -> no ack, adr3 unchanged, next transaction works normally.
// 4 Hold uip_to_drm_tready=0 for 3 cycles mid-DATA -> drm_to_uip_tready=0, response held stable, no beat lost.
// 5 cyc=1,cs=0 transaction of 40 beats -> 40 responses, dat=0, ack=0, no register change.
// 6 Assert drm_arstn=0 mid-read -> outputs 0 immediately; after release IDLE, meter_count=0, activated=0.

Source files
------------

// File: rtl/drm_activator_stream_endpoint.sv
// DRM bus endpoint over AXI4-Stream: decodes controller beats, runs a bit-serial
// four-register slave and returns one registered response beat per accepted beat.
module drm_activator_stream_endpoint #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned METER_THRESH = 1
) (
    input  logic              drm_aclk,
    input  logic              drm_arstn,
    input  logic              drm_to_uip_tvalid,
    input  logic [31:0]       drm_to_uip_tdata,
    output logic              drm_to_uip_tready,
    output logic              uip_to_drm_tvalid,
    output logic [31:0]       uip_to_drm_tdata,
    input  logic              uip_to_drm_tready,
    input  logic              metering_event,
    output logic              activated,
    output logic [DATA_W-1:0] activation_code
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] THRESH   = DATA_W'(METER_THRESH);

    localparam logic [1:0] ADR_STATUS  = 2'd0;
    localparam logic [1:0] ADR_CTRL    = 2'd1;
    localparam logic [1:0] ADR_METER   = 2'd2;
    localparam logic [1:0] ADR_SCRATCH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ACK,
        ST_WAIT,
        ST_SKIP
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         adr_q, adr_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;

    logic [DATA_W-1:0]  ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  meter_q, meter_d;
    logic [DATA_W-1:0]  scratch_q, scratch_d;

    logic               rsp_valid_q;
    logic [31:0]        rsp_data_q;

    logic               beat;
    logic               in_dat, in_we, in_cyc, in_cs;
    logic [1:0]         in_adr;
    logic               intr, sta;
    logic               resp_dat, resp_ack, commit, meter_clear;
    logic [DATA_W-1:0]  rd_data;
    logic               unused_tdata;

    assign in_dat = drm_to_uip_tdata[0];
    assign in_we  = drm_to_uip_tdata[1];
    assign in_adr = drm_to_uip_tdata[3:2];
    assign in_cyc = drm_to_uip_tdata[4];
    assign in_cs  = drm_to_uip_tdata[5];
    assign unused_tdata = ^drm_to_uip_tdata[31:6];

    // Ready is forced low in reset so no beat can be taken while state is cleared.
    assign drm_to_uip_tready = drm_arstn & (~rsp_valid_q | uip_to_drm_tready);
    assign beat              = drm_to_uip_tvalid & drm_to_uip_tready;

    assign intr = (meter_q >= THRESH);
    assign sta  = ctrl_q[0];

    always_comb begin
        rd_data = '0;
        case (in_adr)
            ADR_STATUS:  rd_data = {{(DATA_W-2){1'b0}}, intr, sta};
            ADR_CTRL:    rd_data = ctrl_q;
            ADR_METER:   rd_data = meter_q;
            ADR_SCRATCH: rd_data = scratch_q;
            default:     rd_data = '0;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        resp_dat = 1'b0;
        resp_ack = 1'b0;
        commit   = 1'b0;
        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_cyc && in_cs) begin
                        we_d     = in_we;
                        adr_d    = in_adr;
                        bitcnt_d = '0;
                        if (!in_we) shift_d = rd_data;
                        state_d  = ST_DATA;
                    end else if (in_cyc) begin
                        state_d = ST_SKIP;
                    end
                end
                ST_DATA: begin
                    if (!in_cyc) begin
                        state_d = ST_IDLE;
                    end else begin
                        // One register shifts writes in and reads out, MSB first.
                        resp_dat = ~we_q & shift_q[DATA_W-1];
                        shift_d  = {shift_q[DATA_W-2:0], in_dat};
                        if (bitcnt_q == LAST_BIT) state_d = ST_ACK;
                        else                      bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!in_cyc) begin
                        state_d = ST_IDLE;
                    end else begin
                        resp_ack = 1'b1;
                        commit   = we_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT, ST_SKIP: begin
                    if (!in_cyc) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A status write clears the meter only through bit 1; a meter write always clears it.
    assign meter_clear = commit &&
                         ((adr_q == ADR_METER) || ((adr_q == ADR_STATUS) && shift_q[1]));

    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        meter_d   = meter_q;
        if (commit && adr_q == ADR_CTRL)    ctrl_d    = shift_q;
        if (commit && adr_q == ADR_SCRATCH) scratch_d = shift_q;
        if (meter_clear) begin
            meter_d = metering_event ? DATA_W'(1) : '0;
        end else if (metering_event && meter_q != '1) begin
            meter_d = meter_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            ctrl_q      <= '0;
            meter_q     <= '0;
            scratch_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            ctrl_q    <= ctrl_d;
            meter_q   <= meter_d;
            scratch_q <= scratch_d;
            if (beat) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= {28'd0, resp_ack, intr, sta, resp_dat};
            end else if (uip_to_drm_tready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign uip_to_drm_tvalid = rsp_valid_q;
    assign uip_to_drm_tdata  = rsp_data_q;
    assign activated         = ctrl_q[0];
    assign activation_code   = ctrl_q;

endmodule

// File: tb/tb_drm_activator_stream_endpoint.sv
// Directed bench for drm_activator_stream_endpoint; expected response beats are queued
// as stimulus is driven and compared as the endpoint returns them.
module tb_drm_activator_stream_endpoint;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          d2u_tvalid = 1'b0;
    logic [31:0]   d2u_tdata = '0;
    logic          d2u_tready;
    logic          u2d_tvalid;
    logic [31:0]   u2d_tdata;
    logic          u2d_tready = 1'b1;
    logic          metering_event = 1'b0;
    logic          activated;
    logic [W-1:0]  activation_code;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ctrl_m    = '0;
    logic [31:0] meter_m   = '0;

    always #5 clk = ~clk;

    drm_activator_stream_endpoint #(.DATA_W(W), .METER_THRESH(1)) dut (
        .drm_aclk          (clk),
        .drm_arstn         (rst_n),
        .drm_to_uip_tvalid (d2u_tvalid),
        .drm_to_uip_tdata  (d2u_tdata),
        .drm_to_uip_tready (d2u_tready),
        .uip_to_drm_tvalid (u2d_tvalid),
        .uip_to_drm_tdata  (u2d_tdata),
        .uip_to_drm_tready (u2d_tready),
        .metering_event    (metering_event),
        .activated         (activated),
        .activation_code   (activation_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Response word as the endpoint should build it from the current register state.
    function automatic logic [31:0] resp(input logic dat, input logic ack);
        return {28'd0, ack, (meter_m != 0), ctrl_m[0], dat};
    endfunction

    always @(negedge clk) begin
        if (rst_n && u2d_tvalid && u2d_tready) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   check("resp", u2d_tdata, exp_q.pop_front());
        end
    end

    // Drives one controller beat (called just after a rising edge) and queues its response.
    task automatic beat(input logic cyc, input logic cs, input logic we,
                        input logic [1:0] adr, input logic dat, input logic [31:0] expv);
        logic [31:0] r;
        int n;
        r = $urandom();
        n = 0;
        exp_q.push_back(expv);
        d2u_tvalid = 1'b1;
        d2u_tdata  = {r[31:6], cs, cyc, adr, we, dat};
        do begin
            @(negedge clk);
            n++;
        end while (!d2u_tready && n < 100);
        check("beat_accept", d2u_tready, 1);
        @(posedge clk);
        #1;
        d2u_tvalid = 1'b0;
    endtask

    task automatic write_txn(input logic [1:0] adr, input logic [31:0] data, input int nbits);
        beat(1, 1, 1, adr, 0, resp(0, 0));
        for (int i = 0; i < nbits; i++) beat(1, 1, 1, adr, data[W-1-i], resp(0, 0));
        if (nbits == W) begin
            beat(1, 1, 1, adr, 0, resp(0, 1));
            if (adr == 2'd1) ctrl_m = data;
            if (adr == 2'd2 || (adr == 2'd0 && data[1])) meter_m = '0;
        end
        beat(0, 0, 0, 2'd0, 0, resp(0, 0));
    endtask

    task automatic read_txn(input logic [1:0] adr, input logic [31:0] v, input int stall_at);
        logic [31:0] held;
        beat(1, 1, 0, adr, 0, resp(0, 0));
        for (int i = 0; i < W; i++) begin
            if (i == stall_at) begin
                u2d_tready = 1'b0;
                held = u2d_tdata;
                fork
                    beat(1, 1, 0, adr, 0, resp(v[W-1-i], 0));
                    begin
                        repeat (3) begin
                            @(negedge clk);
                            check("stall_tready", d2u_tready, 0);
                            check("stall_valid", u2d_tvalid, 1);
                            check("stall_hold", u2d_tdata, held);
                        end
                        @(posedge clk);
                        #1;
                        u2d_tready = 1'b1;
                    end
                join
            end else begin
                beat(1, 1, 0, adr, 0, resp(v[W-1-i], 0));
            end
        end
        beat(1, 1, 0, adr, 0, resp(0, 1));
        beat(0, 0, 0, 2'd0, 0, resp(0, 0));
    endtask

    task automatic pulse_meter(input int n);
        repeat (n) begin
            metering_event = 1'b1;
            @(posedge clk);
            #1;
            metering_event = 1'b0;
            meter_m = meter_m + 1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_d2u_tready", d2u_tready, 0);
        check("rst_u2d_tvalid", u2d_tvalid, 0);
        check("rst_u2d_tdata", u2d_tdata, 32'd0);
        check("rst_activated", activated, 0);
        check("rst_code", activation_code, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Activation write to CTRL
        write_txn(2'd1, 32'h0000_0001, W);
        check("t1_activated", activated, 1);
        check("t1_code", activation_code, 32'h0000_0001);

        // Metering, read-back, interrupt and clear by meter write
        pulse_meter(5);
        read_txn(2'd2, 32'h0000_0005, -1);
        write_txn(2'd2, 32'h0000_1234, W);
        read_txn(2'd2, 32'h0000_0000, -1);

        // STATUS bit1 clears the meter, other bits ignored
        pulse_meter(2);
        write_txn(2'd0, 32'hFFFF_FFF2, W);
        read_txn(2'd0, 32'h0000_0001, -1);
        check("t2_activated_kept", activated, 1);

        // Aborted write leaves SCRATCH unchanged
        write_txn(2'd3, 32'hA5A5_1234, W);
        write_txn(2'd3, 32'hFFFF_0000, 10);
        read_txn(2'd3, 32'hA5A5_1234, -1);

        // Back-pressure in the middle of a read
        read_txn(2'd1, 32'h0000_0001, 5);

        // Deselected transaction of 40 beats
        for (int i = 0; i < 40; i++) beat(1, 0, 1, 2'(i), 1, resp(0, 0));
        beat(0, 0, 0, 2'd0, 0, resp(0, 0));
        read_txn(2'd3, 32'hA5A5_1234, -1);
        read_txn(2'd1, 32'h0000_0001, -1);

        // Reset in the middle of a read
        pulse_meter(3);
        beat(1, 1, 0, 2'd2, 0, resp(0, 0));
        for (int i = 0; i < 8; i++) beat(1, 1, 0, 2'd2, 0, resp(0, 0));
        rst_n = 1'b0;
        #1;
        check("t6_u2d_tvalid", u2d_tvalid, 0);
        check("t6_u2d_tdata", u2d_tdata, 32'd0);
        check("t6_d2u_tready", d2u_tready, 0);
        check("t6_activated", activated, 0);
        check("t6_code", activation_code, 32'd0);
        exp_q.delete();
        ctrl_m  = '0;
        meter_m = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_txn(2'd2, 32'h0000_0000, -1);
        read_txn(2'd0, 32'h0000_0000, -1);
        read_txn(2'd3, 32'h0000_0000, -1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
